// File: rtl/spi_frame_ctrl_pkg.sv
// Shared parameters for the SPI frame controller: pixel width, frame size and FSM state encoding.
package spi_frame_ctrl_pkg;

  localparam int MAX_PIXEL_BITS = 8;
  localparam int FRAME_PIXELS   = 16384;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PUSH   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/spi_frame_ctrl_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level into the clk_i domain.
module bit_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI slave frame controller: turns synced SPI byte events into a pixel stream and feeds result bytes back.
// Optional sticky overrun flag enabled by defining SPI_CTRL_OVERRUN_EN.
module spi_frame_ctrl
  import spi_frame_ctrl_pkg::*;
#(
  parameter int MAX_PIXEL_BITS = spi_frame_ctrl_pkg::MAX_PIXEL_BITS,
  parameter int FRAME_PIXELS   = spi_frame_ctrl_pkg::FRAME_PIXELS
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cs_i,
  input  logic                      rx_done_i,
  input  logic [MAX_PIXEL_BITS-1:0] rx_data_i,
  output logic [MAX_PIXEL_BITS-1:0] tx_data_o,
  output logic                      pix_valid_o,
  output logic [MAX_PIXEL_BITS-1:0] pix_data_o,
  input  logic                      pix_ready_i,
  input  logic                      res_valid_i,
  input  logic [MAX_PIXEL_BITS-1:0] res_data_i,
  output logic                      res_ready_o,
  output logic                      frame_start_o,
  output logic                      frame_done_o,
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int                CNT_W   = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FRAME_PIXELS);

  logic cs_s, rx_s;
  logic cs_prev_q, rx_prev_q;
  logic cs_fall, byte_ev;

  bit_sync u_cs_sync (.clk_i(clk_i), .rst_i(rst_i), .d_i(cs_i),      .q_o(cs_s));
  bit_sync u_rx_sync (.clk_i(clk_i), .rst_i(rst_i), .d_i(rx_done_i), .q_o(rx_s));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_prev_q <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      cs_prev_q <= cs_s;
      rx_prev_q <= rx_s;
    end
  end

  assign cs_fall = cs_prev_q & ~cs_s;
  assign byte_ev = rx_s & ~rx_prev_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_full;

  assign cnt_full = (cnt_q == CNT_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A full frame wins over a late byte so the extra byte is never pushed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE: begin
        if (cnt_full)     state_d = DONE;
        else if (byte_ev) state_d = PUSH;
        else if (cs_s)    state_d = DONE;
      end
      PUSH:    if (pix_ready_i) state_d = ACTIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_start_o = (state_q == IDLE) && cs_fall;
    frame_done_o  = (state_q == DONE);
    busy_o        = (state_q != IDLE);
    pix_valid_o   = (state_q == PUSH);
  end

  logic [MAX_PIXEL_BITS-1:0] pix_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      pix_data_q <= '0;
    end else begin
      if (frame_start_o)
        cnt_q <= '0;
      else if (pix_valid_o && pix_ready_i && !cnt_full)
        cnt_q <= cnt_q + 1'b1;
      if ((state_q == ACTIVE) && !cnt_full && byte_ev)
        pix_data_q <= rx_data_i;
    end
  end

  assign pix_data_o = pix_data_q;

  // TX slot: a result load beats the byte event that would otherwise drain it.
  logic                      tx_full_q, tx_full_d;
  logic [MAX_PIXEL_BITS-1:0] tx_data_q, tx_data_d;
  logic                      res_ready_q;
  logic                      res_hs;

  assign res_hs = res_valid_i && res_ready_q;

  always_comb begin
    tx_full_d = tx_full_q;
    tx_data_d = tx_data_q;
    if (res_hs) begin
      tx_full_d = 1'b1;
      tx_data_d = res_data_i;
    end else if (byte_ev) begin
      tx_full_d = 1'b0;
      if (!tx_full_q) tx_data_d = '0;
    end
  end

  // Ready is registered so it reads 0 while reset is held, even though the slot is empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_full_q   <= 1'b0;
      tx_data_q   <= '0;
      res_ready_q <= 1'b0;
    end else begin
      tx_full_q   <= tx_full_d;
      tx_data_q   <= tx_data_d;
      res_ready_q <= ~tx_full_d;
    end
  end

  assign tx_data_o   = tx_data_q;
  assign res_ready_o = res_ready_q;

`ifdef SPI_CTRL_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                             overrun_q <= 1'b0;
    else if (frame_start_o)                overrun_q <= 1'b0;
    else if (byte_ev && (state_q == PUSH)) overrun_q <= 1'b1;
  end

  assign overrun_o = overrun_q;
`else
  assign overrun_o = 1'b0;
`endif

endmodule
